uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
- REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning CLK cycles per serial bit (legal 1..65535).
- REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
- REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning parity sense (0 even, 1 odd); used only when UART_TX_PARITY_EN is defined.
- REQ-005 SHALL have port CLK  input  1  sole clock, rising-edge.
- REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
- REQ-007 SHALL have port data  input  DATA_BITS  payload to send.
- REQ-008 SHALL have port valid  input  1  data is offered.
- REQ-009 SHALL have port ready  output  1  block can accept data this cycle.
- REQ-010 SHALL have port O  output  1  serial line, idle high.
- REQ-011 SHALL have port busy  output  1  frame in progress.

Function
- REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- REQ-013 SHALL treat a transfer as accepted on any rising edge where valid=1 and ready=1; data is captured into an internal shift register on that edge.
- REQ-014 SHALL drive ready=1 in IDLE and in the final CLK cycle of the final stop bit; ready=0 otherwise.
- REQ-015 SHALL hold every serial bit on O for exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1 and restarts at 0 on every bit boundary.
- REQ-016 SHALL drive the start bit (O=0) from the cycle after acceptance, so latency is 1 cycle.
- REQ-017 SHALL send data LSB first, DATA_BITS bits, then the parity bit if enabled, then STOP_BITS stop bits (O=1).
- REQ-018 SHALL make total frame length exactly (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
- REQ-019 SHALL go STOP->START directly with no idle gap when acceptance happens in the final stop cycle; otherwise it SHALL go STOP->IDLE.
- REQ-020 SHALL ignore data and valid while ready=0; data may change freely after acceptance.
- REQ-021 SHALL drive busy=1 in START, DATA, PARITY and STOP, and busy=0 in IDLE.
- REQ-022 SHALL drive O from a register, glitch-free.
- REQ-023 SHALL hold O=1 in IDLE.
- REQ-024 SHALL behave correctly with CLKS_PER_BIT=1, i.e. one bit per cycle.

Reset
- REQ-025 SHALL, while RESET=0, asynchronously force state IDLE, O=1, ready=1, busy=0, and clear the baud counter, bit counter and shift register.
- REQ-026 SHALL abort any frame in progress when reset is asserted mid-frame; O returns high immediately and no partial frame resumes.
- REQ-027 SHALL permit the first acceptance on the first rising edge after RESET deasserts.

Configuration
- REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, insert one parity bit after the data bits.
- REQ-029 SHALL set that parity bit to the XOR of the data bits for PARITY_ODD=0, and to its inverse for PARITY_ODD=1.
- REQ-030 SHALL, with UART_TX_PARITY_EN undefined, have no PARITY state and no parity logic, and SHALL ignore PARITY_ODD.

Verification
- REQ-031 SHALL cover defaults, no parity, send 0xA5 -> O = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total, ready=1 only in the 40th.
- REQ-032 SHALL cover two transfers, 0x00 then 0xFF, with valid held high -> second start bit begins at cycle 41 with no gap, and the first stop bit lasts exactly 4 cycles.
- REQ-033 SHALL cover UART_TX_PARITY_EN defined, PARITY_ODD=0, sending 0x07 -> parity bit=1 and frame=44 cycles; with PARITY_ODD=1 -> parity bit=0.
- REQ-034 SHALL cover DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=1, sending 0x13 -> O = 0,1,1,0,0,1,1,1 over 8 cycles.
- REQ-035 SHALL cover RESET pulsed low at cycle 10 of a frame -> O=1, busy=0, ready=1 within the same cycle, and a new frame for 0x3C is then sent intact.
- REQ-036 SHALL cover valid asserted at cycle 5 of a frame with a different data value -> no acceptance, and the frame in flight is unchanged.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 O,
  output logic                 busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 o_q, o_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic accept;
  logic bit_end;

  assign accept  = valid && ready_q;
  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    o_d     = o_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        baud_d = '0;
        o_d    = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          o_d     = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            o_d     = par_q;
`else
            state_d = StStop;
            o_d     = 1'b1;
`endif
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 4'd1;
            o_d     = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          o_d     = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        bit_d   = '0;
        o_d     = 1'b1;
      end
    endcase

    // ready_q is only high in IDLE or the last stop cycle, so this also covers STOP->START
    if (accept) begin
      state_d = StStart;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = data;
      o_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^data) ^ 1'(PARITY_ODD);
`endif
    end

    ready_d = (state_d == StIdle) ||
              ((state_d == StStop) && (bit_d == StopLast) && (baud_d == BaudLast));
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      o_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      o_q     <= o_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign O     = o_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (default and 5-bit/2-stop/1-clk) against a queue-based
// line model that expands each accepted frame into its expected per-cycle O values.
module tb_uart_tx;

  localparam int CpbA = 4;
  localparam int NbA  = 8;
  localparam int SbA  = 1;
  localparam int OddA = 0;
  localparam int CpbB = 1;
  localparam int NbB  = 5;
  localparam int SbB  = 2;
  localparam int OddB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int ParBits = 1;
`else
  localparam int ParBits = 0;
`endif
  localparam int FrameA = (1 + NbA + ParBits + SbA) * CpbA;
  localparam int FrameB = (1 + NbB + ParBits + SbB) * CpbB;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] data_a = '0;
  logic       valid_a = 1'b0;
  logic       ready_a, o_a, busy_a;
  logic [4:0] data_b = '0;
  logic       valid_b = 1'b0;
  logic       ready_b, o_b, busy_b;

  always #5 CLK = ~CLK;

  uart_tx #(.DATA_BITS(NbA), .CLKS_PER_BIT(CpbA), .STOP_BITS(SbA), .PARITY_ODD(OddA)) dut_a (
    .CLK(CLK), .RESET(RESET), .data(data_a), .valid(valid_a),
    .ready(ready_a), .O(o_a), .busy(busy_a)
  );

  uart_tx #(.DATA_BITS(NbB), .CLKS_PER_BIT(CpbB), .STOP_BITS(SbB), .PARITY_ODD(OddB)) dut_b (
    .CLK(CLK), .RESET(RESET), .data(data_b), .valid(valid_b),
    .ready(ready_b), .O(o_b), .busy(busy_b)
  );

  int nvec = 0;
  int nerr = 0;

  // Pending line values per cycle; expected {O, ready, busy} for the current cycle.
  logic       q_a[$];
  logic       q_b[$];
  logic [2:0] exp_a = 3'b110;
  logic [2:0] exp_b = 3'b110;

  // Frame bits in send order (index 0 first on the line); returns the bit count.
  function automatic int build_frame(input logic [8:0] d, input int nb, input int sb,
                                     input int odd, output logic [15:0] f);
    int   n = 0;
    logic p = (odd != 0);
    f = '0;
    f[n] = 1'b0;
    n++;
    for (int i = 0; i < nb; i++) begin
      f[n] = d[i];
      p    = p ^ d[i];
      n++;
    end
`ifdef UART_TX_PARITY_EN
    f[n] = p;
    n++;
`endif
    for (int i = 0; i < sb; i++) begin
      f[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    exp_a = 3'b110;
    exp_b = 3'b110;
  endtask

  // Advance one clock, update the model, and leave time 1 unit after the edge.
  task automatic tick();
    logic [15:0] f;
    int          n;
    logic        acc_a, acc_b, o;
    logic [8:0]  da, db;
    acc_a = valid_a && exp_a[1];
    acc_b = valid_b && exp_b[1];
    da = {1'b0, data_a};
    db = {4'b0, data_b};
    @(posedge CLK);
    if (acc_a) begin
      n = build_frame(da, NbA, SbA, OddA, f);
      for (int j = 0; j < n; j++) repeat (CpbA) q_a.push_back(f[j]);
    end
    if (acc_b) begin
      n = build_frame(db, NbB, SbB, OddB, f);
      for (int j = 0; j < n; j++) repeat (CpbB) q_b.push_back(f[j]);
    end
    if (q_a.size() > 0) begin
      o = q_a.pop_front();
      exp_a = {o, q_a.size() == 0, 1'b1};
    end else begin
      exp_a = 3'b110;
    end
    if (q_b.size() > 0) begin
      o = q_b.pop_front();
      exp_b = {o, q_b.size() == 0, 1'b1};
    end else begin
      exp_b = 3'b110;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 RESET = 1'b0;
    #1;
    nvec++;
    if ({o_a, ready_a, busy_a} !== 3'b110) begin
      nerr++;
      $display("FAIL reset_a: O/ready/busy got %b want 110", {o_a, ready_a, busy_a});
    end
    nvec++;
    if ({o_b, ready_b, busy_b} !== 3'b110) begin
      nerr++;
      $display("FAIL reset_b: O/ready/busy got %b want 110", {o_b, ready_b, busy_b});
    end
    valid_a = 1'b1;
    valid_b = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    nvec++;
    if ({o_a, ready_a, busy_a, o_b, ready_b, busy_b} !== 6'b110110) begin
      nerr++;
      $display("FAIL reset_hold: got %b want 110110", {o_a, ready_a, busy_a, o_b, ready_b, busy_b});
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    RESET = 1'b1;
    model_reset();
  endtask

  task automatic test_frame_a5();
    logic [9:0] seq = 10'b1101001010;
    logic [2:0] want;
    data_a = 8'hA5;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    data_a = 8'($urandom);
    for (int k = 0; k < FrameA + 4; k++) begin
      nvec++;
      if ({o_a, ready_a, busy_a} !== exp_a) begin
        nerr++;
        $display("FAIL frame_a5 cyc %0d: got %b want %b", k, {o_a, ready_a, busy_a}, exp_a);
      end
`ifndef UART_TX_PARITY_EN
      want = (k < 40) ? {seq[k/4], (k == 39), 1'b1} : 3'b110;
      nvec++;
      if ({o_a, ready_a, busy_a} !== want) begin
        nerr++;
        $display("FAIL frame_a5_lit cyc %0d: got %b want %b", k, {o_a, ready_a, busy_a}, want);
      end
`endif
      tick();
    end
  endtask

  task automatic test_back_to_back();
    data_a = 8'h00;
    valid_a = 1'b1;
    tick();
    data_a = 8'hFF;
    for (int k = 0; k < 2 * FrameA + 4; k++) begin
      if (k == FrameA) valid_a = 1'b0;
      nvec++;
      if ({o_a, ready_a, busy_a} !== exp_a) begin
        nerr++;
        $display("FAIL b2b cyc %0d: got %b want %b", k, {o_a, ready_a, busy_a}, exp_a);
      end
`ifndef UART_TX_PARITY_EN
      if (k >= 36 && k <= 40) begin
        nvec++;
        if ({o_a, ready_a, busy_a} !== ((k == 40) ? 3'b001 : {1'b1, k == 39, 1'b1})) begin
          nerr++;
          $display("FAIL b2b_stop cyc %0d: got %b want %b", k, {o_a, ready_a, busy_a},
                   (k == 40) ? 3'b001 : {1'b1, k == 39, 1'b1});
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_parity();
    data_a = 8'h07;
    data_b = 5'h07;
    valid_a = 1'b1;
    valid_b = 1'b1;
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int k = 0; k < FrameA + 2; k++) begin
      nvec++;
      if ({o_a, ready_a, busy_a, o_b, ready_b, busy_b} !== {exp_a, exp_b}) begin
        nerr++;
        $display("FAIL parity cyc %0d: got %b want %b", k,
                 {o_a, ready_a, busy_a, o_b, ready_b, busy_b}, {exp_a, exp_b});
      end
`ifdef UART_TX_PARITY_EN
      if (k == 36 || k == 43 || k == 44) begin
        nvec++;
        if ({o_a, ready_a, busy_a} !== ((k == 36) ? 3'b101 : (k == 43) ? 3'b111 : 3'b110)) begin
          nerr++;
          $display("FAIL parity_even_a cyc %0d: got %b", k, {o_a, ready_a, busy_a});
        end
      end
      if (k == 6) begin
        nvec++;
        if (o_b !== 1'b0) begin
          nerr++;
          $display("FAIL parity_odd_b: O got %b want 0", o_b);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_small_cfg();
    logic [7:0] seq = 8'b11100110;
    data_b = 5'h13;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int k = 0; k < FrameB + 3; k++) begin
      nvec++;
      if ({o_b, ready_b, busy_b} !== exp_b) begin
        nerr++;
        $display("FAIL small_cfg cyc %0d: got %b want %b", k, {o_b, ready_b, busy_b}, exp_b);
      end
`ifndef UART_TX_PARITY_EN
      if (k < 8) begin
        nvec++;
        if ({o_b, ready_b} !== {seq[k], k == 7}) begin
          nerr++;
          $display("FAIL small_cfg_lit cyc %0d: O/ready got %b want %b", k, {o_b, ready_b},
                   {seq[k], k == 7});
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    data_a = 8'h96;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #2 RESET = 1'b0;
    #1;
    nvec++;
    if ({o_a, ready_a, busy_a} !== 3'b110) begin
      nerr++;
      $display("FAIL reset_mid: got %b want 110", {o_a, ready_a, busy_a});
    end
    model_reset();
    #1 RESET = 1'b1;
    data_a = 8'h3C;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    nvec++;
    if ({o_a, ready_a, busy_a} !== 3'b001) begin
      nerr++;
      $display("FAIL reset_mid_start: got %b want 001", {o_a, ready_a, busy_a});
    end
    for (int k = 0; k < FrameA + 2; k++) begin
      nvec++;
      if ({o_a, ready_a, busy_a} !== exp_a) begin
        nerr++;
        $display("FAIL reset_mid_3c cyc %0d: got %b want %b", k, {o_a, ready_a, busy_a}, exp_a);
      end
      tick();
    end
  endtask

  task automatic test_ignore_valid();
    data_a = 8'h5A;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int k = 0; k < FrameA + 3; k++) begin
      if (k == 5) begin
        data_a = 8'hC3;
        valid_a = 1'b1;
      end
      if (k == 20) valid_a = 1'b0;
      nvec++;
      if ({o_a, ready_a, busy_a} !== exp_a) begin
        nerr++;
        $display("FAIL ignore_valid cyc %0d: got %b want %b", k, {o_a, ready_a, busy_a}, exp_a);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      data_a = 8'($urandom);
      data_b = 5'($urandom);
      valid_a = ($urandom_range(0, 3) == 0);
      valid_b = ($urandom_range(0, 2) == 0);
      tick();
      nvec++;
      if ({o_a, ready_a, busy_a, o_b, ready_b, busy_b} !== {exp_a, exp_b}) begin
        nerr++;
        $display("FAIL random cyc %0d: got %b want %b", k,
                 {o_a, ready_a, busy_a, o_b, ready_b, busy_b}, {exp_a, exp_b});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_parity();
    test_small_cfg();
    test_reset_midframe();
    test_ignore_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
